// File: rtl/escalonador_pkg.sv
// Shared definitions for the round-robin process scheduler:
// state encoding, OS pid and default sizing.
package escalonador_pkg;

  localparam int unsigned DEF_NPROC     = 4;
  localparam int unsigned DEF_PID_W     = 2;
  localparam int unsigned DEF_QUANTUM_W = 16;
  localparam int unsigned OS_PID        = 0;

  typedef enum logic [1:0] {
    S_OS    = 2'd0,
    S_USER  = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/seletor_rr.sv
// Round-robin selector: first ready user pid after last_pid, wrapping and
// skipping the OS slot; last_pid itself is the final candidate.
module seletor_rr #(
  parameter  int unsigned NPROC = 4,
  localparam int unsigned PID_W = $clog2(NPROC)
) (
  input  logic [NPROC-1:0] ready_mask,
  input  logic [PID_W-1:0] last_pid,
  output logic [PID_W-1:0] nxt_c,
  output logic             any_ready_c
);

  logic [PID_W-1:0] cand;

  always_comb begin
    nxt_c       = '0;
    any_ready_c = 1'b0;
    cand        = '0;
    for (int unsigned i = 1; i <= NPROC; i++) begin
      cand = last_pid + PID_W'(i);
      if (!any_ready_c && (cand != '0) && ready_mask[cand]) begin
        nxt_c       = cand;
        any_ready_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/escalonador_processos.sv
// Process scheduler: owns id_proc, rotates dispatch among ready user
// processes and forces a return to the OS when the quantum expires.
module escalonador_processos
  import escalonador_pkg::*;
#(
  parameter int unsigned NPROC     = DEF_NPROC,
  parameter int unsigned PID_W     = DEF_PID_W,
  parameter int unsigned QUANTUM_W = DEF_QUANTUM_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 preemp_mode,
  input  logic [QUANTUM_W-1:0] quantum,
  input  logic                 Set_ctx,
  input  logic                 Set_pid_0,
  input  logic                 HALT,
  input  logic                 WAIT,
  input  logic [NPROC-1:0]     ready_set,
  output logic [PID_W-1:0]     id_proc,
  output logic                 preempt_req,
  output logic [NPROC-1:0]     ready_mask,
  output logic [PID_W-1:0]     last_pid,
  output logic                 no_ready,
  output logic                 sys_halted
);

  localparam logic [NPROC-1:0] OS_BIT = NPROC'(1);

  state_t               state_q, state_d;
  logic [PID_W-1:0]     id_proc_q, id_proc_d;
  logic [PID_W-1:0]     last_pid_q, last_pid_d;
  logic [NPROC-1:0]     ready_mask_q, ready_mask_d;
  logic [NPROC-1:0]     clr_mask;
  logic [QUANTUM_W-1:0] counter_q, counter_d;
  logic                 preempt_req_q, preempt_req_d;
  logic                 no_ready_q, no_ready_d;
  logic                 sys_halted_q, sys_halted_d;
  logic [PID_W-1:0]     nxt;
  logic                 any_ready;

  seletor_rr #(.NPROC(NPROC)) u_seletor_rr (
    .ready_mask  (ready_mask_q),
    .last_pid    (last_pid_q),
    .nxt_c       (nxt),
    .any_ready_c (any_ready)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_OS;
      id_proc_q     <= PID_W'(OS_PID);
      last_pid_q    <= PID_W'(NPROC - 1);
      ready_mask_q  <= '0;
      counter_q     <= '0;
      preempt_req_q <= 1'b0;
      no_ready_q    <= 1'b0;
      sys_halted_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      id_proc_q     <= id_proc_d;
      last_pid_q    <= last_pid_d;
      ready_mask_q  <= ready_mask_d;
      counter_q     <= counter_d;
      preempt_req_q <= preempt_req_d;
      no_ready_q    <= no_ready_d;
      sys_halted_q  <= sys_halted_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    id_proc_d     = id_proc_q;
    last_pid_d    = last_pid_q;
    ready_mask_d  = ready_mask_q;
    counter_d     = counter_q;
    preempt_req_d = preempt_req_q;
    no_ready_d    = 1'b0;
    sys_halted_d  = sys_halted_q;
    clr_mask      = '0;

    unique case (state_q)
      S_OS: begin
        if (HALT) begin
          state_d      = S_HALT;
          sys_halted_d = 1'b1;
        end else if (Set_ctx) begin
          if (any_ready) begin
            state_d    = S_USER;
            id_proc_d  = nxt;
            last_pid_d = nxt;
            counter_d  = (quantum == '0) ? QUANTUM_W'(1) : quantum;
          end else begin
            no_ready_d = 1'b1;
          end
        end
      end
      S_USER: begin
        if (HALT) begin
          clr_mask[id_proc_q] = 1'b1;
          id_proc_d           = PID_W'(OS_PID);
          state_d             = S_OS;
        end else if (Set_pid_0) begin
          id_proc_d = PID_W'(OS_PID);
          state_d   = S_OS;
        end else if (preemp_mode && !WAIT) begin
          if (counter_q <= QUANTUM_W'(1)) begin
            preempt_req_d = 1'b1;
            counter_d     = '0;
            state_d       = S_DRAIN;
          end else begin
            counter_d = counter_q - QUANTUM_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (HALT) begin
          clr_mask[id_proc_q] = 1'b1;
          preempt_req_d       = 1'b0;
          id_proc_d           = PID_W'(OS_PID);
          state_d             = S_OS;
        end else if (Set_pid_0) begin
          preempt_req_d = 1'b0;
          id_proc_d     = PID_W'(OS_PID);
          state_d       = S_OS;
        end
      end
      S_HALT: begin
      end
      default: state_d = S_OS;
    endcase

    // Clear is applied after the OR so a halting process cannot be re-marked in the same cycle.
    if (state_q != S_HALT) begin
      ready_mask_d = (ready_mask_q | (ready_set & ~OS_BIT)) & ~clr_mask;
    end
  end

  assign id_proc     = id_proc_q;
  assign preempt_req = preempt_req_q;
  assign ready_mask  = ready_mask_q;
  assign last_pid    = last_pid_q;
  assign no_ready    = no_ready_q;
  assign sys_halted  = sys_halted_q;

endmodule
